// File: rtl/sys_bus_pkg.sv
// Shared bus definitions: responder state encoding, MMIO register map and
// the byte-enable legality check used by every bus master and target.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAM_RD = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam int unsigned LEDR_OFF = 'h00;
  localparam int unsigned HEX_OFF  = 'h04;
  localparam int unsigned SW_OFF   = 'h08;
  localparam int unsigned KEY_OFF  = 'h0C;

  // Byte, aligned halfword and full word lane patterns only.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mmio_regfile.sv
// Board I/O registers behind the MMIO window: LEDR/HEX storage, SW/KEY
// synchronisers, offset decode and the access-error flag.
module mmio_regfile
  import sys_bus_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] offset_i,
  input  logic [2:0]        be_i,
  input  logic [23:0]       wdata_i,
  input  logic [9:0]        sw_i,
  input  logic [3:0]        key_i,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [9:0]        ledr_o,
  output logic [23:0]       hex_o
);

  logic [9:0]  ledr_q, ledr_d;
  logic [23:0] hex_q, hex_d;
  logic [9:0]  sw_meta_q, sw_sync_q;
  logic [3:0]  key_meta_q, key_sync_q;
  logic        hit_ledr, hit_hex, hit_sw, hit_key;

  always_comb begin
    hit_ledr = (offset_i == ADDR_W'(LEDR_OFF));
    hit_hex  = (offset_i == ADDR_W'(HEX_OFF));
    hit_sw   = (offset_i == ADDR_W'(SW_OFF));
    hit_key  = (offset_i == ADDR_W'(KEY_OFF));
    // SW and KEY are read-only; writing them is an error, not a silent drop.
    err_o    = !(hit_ledr || hit_hex || hit_sw || hit_key) ||
               (we_i && (hit_sw || hit_key));
    rdata_o  = ({32{hit_ledr}} & {22'd0, ledr_q})
             | ({32{hit_hex}}  & {8'd0,  hex_q})
             | ({32{hit_sw}}   & {22'd0, sw_sync_q})
             | ({32{hit_key}}  & {28'd0, key_sync_q});
    ledr_d = ledr_q;
    hex_d  = hex_q;
    if (acc_i && we_i && hit_ledr) begin
      if (be_i[0]) ledr_d[7:0] = wdata_i[7:0];
      if (be_i[1]) ledr_d[9:8] = wdata_i[9:8];
    end
    if (acc_i && we_i && hit_hex) begin
      if (be_i[0]) hex_d[7:0]   = wdata_i[7:0];
      if (be_i[1]) hex_d[15:8]  = wdata_i[15:8];
      if (be_i[2]) hex_d[23:16] = wdata_i[23:16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ledr_q     <= '0;
      hex_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '0;
      key_sync_q <= '0;
    end else begin
      ledr_q     <= ledr_d;
      hex_q      <= hex_d;
      sw_meta_q  <= sw_i;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= key_i;
      key_sync_q <= key_meta_q;
    end
  end

  assign ledr_o = ledr_q;
  assign hex_o  = hex_q;

endmodule

// File: rtl/sys_mem_responder.sv
// Single-outstanding bus target: routes core requests to the synchronous
// system RAM or the MMIO registers and returns one registered response.
module sys_mem_responder
  import sys_bus_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              RAM_LATENCY = 2,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic              ram_wren,
  output logic              ram_rden,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_q,
  input  logic [9:0]        sw,
  input  logic [3:0]        key,
  output logic [9:0]        ledr,
  output logic [23:0]       hex_data
);

  // Both channels are valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; a source holds its payload until then.
  localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-3:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_be_q, ram_be_d;
  logic              ram_wren_q, ram_wren_d;
  logic              ram_rden_q, ram_rden_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic              accept, fmt_err, is_mmio, mmio_acc, mmio_err;
  logic [ADDR_W-1:0] mmio_off;
  logic [31:0]       mmio_rdata;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign fmt_err   = (req_addr[1:0] != 2'b00) || !be_legal(req_be);
  assign is_mmio   = (req_addr >= MMIO_BASE);
  assign mmio_off  = req_addr - MMIO_BASE;
  assign mmio_acc  = accept && is_mmio && !fmt_err;

  mmio_regfile #(.ADDR_W(ADDR_W)) u_mmio (
    .clk      (clk),
    .rst      (rst),
    .acc_i    (mmio_acc),
    .we_i     (req_we),
    .offset_i (mmio_off),
    .be_i     (req_be[2:0]),
    .wdata_i  (req_wdata[23:0]),
    .sw_i     (sw),
    .key_i    (key),
    .rdata_o  (mmio_rdata),
    .err_o    (mmio_err),
    .ledr_o   (ledr),
    .hex_o    (hex_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_addr_d  = '0;
    ram_be_d    = '0;
    ram_wren_d  = 1'b0;
    ram_rden_d  = 1'b0;
    ram_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
          if (fmt_err) begin
            rsp_err_d = 1'b1;
          end else if (is_mmio) begin
            rsp_err_d   = mmio_err;
            rsp_rdata_d = (mmio_err || req_we) ? 32'd0 : mmio_rdata;
          end else begin
            ram_addr_d = req_addr[ADDR_W-1:2];
            ram_be_d   = req_be;
            if (req_we) begin
              ram_wren_d  = 1'b1;
              ram_wdata_d = req_wdata;
            end else begin
              ram_rden_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_RAM_RD;
            end
          end
        end
      end
      ST_RAM_RD: begin
        // The counter starts once the read strobe cycle is over, so it
        // tracks the RAM's own address/output register stages.
        if (!ram_rden_q) begin
          if (cnt_q == CNT_W'(RAM_LATENCY - 1)) begin
            rsp_rdata_d = ram_q;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= '0;
      ram_wren_q  <= 1'b0;
      ram_rden_q  <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ram_addr_q  <= ram_addr_d;
      ram_be_q    <= ram_be_d;
      ram_wren_q  <= ram_wren_d;
      ram_rden_q  <= ram_rden_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_be    = ram_be_q;
  assign ram_wren  = ram_wren_q;
  assign ram_rden  = ram_rden_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder with a two-stage registered RAM model.
module tb_sys_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [13:0] ram_addr;
  logic [3:0]  ram_be;
  logic        ram_wren, ram_rden;
  logic [31:0] ram_wdata, ram_q;
  logic [9:0]  sw, ledr;
  logic [3:0]  key;
  logic [23:0] hex_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sys_mem_responder #(
    .ADDR_W(16), .RAM_LATENCY(2), .MMIO_BASE(16'hFF00)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_be(ram_be), .ram_wren(ram_wren),
    .ram_rden(ram_rden), .ram_wdata(ram_wdata), .ram_q(ram_q),
    .sw(sw), .key(key), .ledr(ledr), .hex_data(hex_data)
  );

  // RAM model: address register then output register (latency 2).
  logic [31:0] mem [0:255];
  logic [7:0]  rd_addr_q;
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    rd_addr_q <= ram_addr[7:0];
    ram_q     <= mem[rd_addr_q];
  end

  // Strobe monitor, sampled mid-cycle.
  int          wren_cnt = 0;
  int          rden_cnt = 0;
  logic [13:0] last_wr_addr;
  logic [3:0]  last_wr_be;
  logic [31:0] last_wr_data;
  logic        rsp_seen = 1'b0;
  always @(negedge clk) begin
    if (ram_wren) begin
      wren_cnt++;
      last_wr_addr = ram_addr;
      last_wr_be   = ram_be;
      last_wr_data = ram_wdata;
    end
    if (ram_rden) rden_cnt++;
    if (rsp_valid) rsp_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; lat = edges from acceptance to rsp_valid.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!rsp_valid && lat < 20);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk) rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, w0, r0;

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    rsp_ready = 1'b0; sw = '0; key = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ram_wren",  32'(ram_wren),  32'd0);
    chk("rst_ram_rden",  32'(ram_rden),  32'd0);
    chk("rst_ledr",      32'(ledr),      32'd0);
    chk("rst_hex",       32'(hex_data),  32'd0);
    @(negedge clk) rst = 1'b1;

    // Full-word RAM write then readback
    w0 = wren_cnt;
    do_req(1'b1, 16'h0010, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    chk("wr_pulses",  32'(wren_cnt - w0), 32'd1);
    chk("wr_addr",    32'(last_wr_addr),  32'h4);
    chk("wr_be",      32'(last_wr_be),    32'hF);
    chk("wr_data",    last_wr_data,       32'hDEADBEEF);
    chk("wr_lat",     32'(lat),           32'd1);
    chk("wr_err",     32'(er),            32'd0);
    chk("wr_rdata",   rd,                 32'd0);
    r0 = rden_cnt;
    do_req(1'b0, 16'h0010, 4'b1111, 32'd0, rd, er, lat);
    chk("rd_pulses",  32'(rden_cnt - r0), 32'd1);
    chk("rd_data",    rd,                 32'hDEADBEEF);
    chk("rd_err",     32'(er),            32'd0);
    chk("rd_lat",     32'(lat),           32'd3);

    // Byte-lane write
    do_req(1'b1, 16'h0010, 4'b0010, 32'h0000AA00, rd, er, lat);
    chk("bw_be",      32'(last_wr_be),    32'h2);
    do_req(1'b0, 16'h0010, 4'b1111, 32'd0, rd, er, lat);
    chk("bw_rd_data", rd,                 32'hDEADAAEF);

    // Illegal accesses
    w0 = wren_cnt; r0 = rden_cnt;
    do_req(1'b0, 16'h0012, 4'b1111, 32'd0, rd, er, lat);
    chk("mis_err",    32'(er),  32'd1);
    chk("mis_rdata",  rd,       32'd0);
    chk("mis_lat",    32'(lat), 32'd1);
    do_req(1'b0, 16'h0010, 4'b0101, 32'd0, rd, er, lat);
    chk("be_err",     32'(er),  32'd1);
    chk("be_rdata",   rd,       32'd0);
    chk("be_lat",     32'(lat), 32'd1);
    do_req(1'b1, 16'h0014, 4'b0110, 32'h12345678, rd, er, lat);
    chk("be_w_err",   32'(er),  32'd1);
    chk("ill_wren",   32'(wren_cnt - w0), 32'd0);
    chk("ill_rden",   32'(rden_cnt - r0), 32'd0);

    // MMIO
    do_req(1'b1, 16'hFF00, 4'b0011, 32'h000003FF, rd, er, lat);
    chk("ledr_w_err", 32'(er),   32'd0);
    chk("ledr_w_lat", 32'(lat),  32'd1);
    chk("ledr_val",   32'(ledr), 32'h3FF);
    do_req(1'b1, 16'hFF00, 4'b0001, 32'h00000000, rd, er, lat);
    chk("ledr_lane",  32'(ledr), 32'h300);
    do_req(1'b0, 16'hFF00, 4'b1111, 32'd0, rd, er, lat);
    chk("ledr_rd",    rd,        32'h300);
    @(negedge clk) sw = 10'h155; key = 4'hA;
    repeat (3) @(posedge clk);
    do_req(1'b0, 16'hFF08, 4'b1111, 32'd0, rd, er, lat);
    chk("sw_rd",      rd,        32'h155);
    chk("sw_rd_err",  32'(er),   32'd0);
    do_req(1'b0, 16'hFF0C, 4'b1111, 32'd0, rd, er, lat);
    chk("key_rd",     rd,        32'hA);
    do_req(1'b1, 16'hFF08, 4'b0011, 32'h000000FF, rd, er, lat);
    chk("sw_w_err",   32'(er),   32'd1);
    chk("sw_w_ledr",  32'(ledr), 32'h300);
    do_req(1'b1, 16'hFF04, 4'b1111, 32'hAB123456, rd, er, lat);
    chk("hex_val",    32'(hex_data), 32'h123456);
    do_req(1'b0, 16'hFF04, 4'b1111, 32'd0, rd, er, lat);
    chk("hex_rd",     rd,        32'h00123456);
    do_req(1'b0, 16'hFF10, 4'b1111, 32'd0, rd, er, lat);
    chk("unmap_err",  32'(er),   32'd1);
    chk("unmap_data", rd,        32'd0);

    // Response back-pressure with a competing request held on req_valid
    w0 = wren_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("stall_first_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_be = 4'hF;
    req_wdata = 32'h11111111;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata,      32'hDEADAAEF);
      chk("stall_err",   32'(rsp_err),   32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk) req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    chk("stall_no_wr", 32'(wren_cnt - w0), 32'd0);
    chk("stall_mem",   mem[8],             32'd0);

    // Reset during RAM_RD
    @(negedge clk);
    rsp_seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    chk("mrst_ledr",      32'(ledr),      32'd0);
    chk("mrst_hex",       32'(hex_data),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("mrst_no_rsp", 32'(rsp_seen), 32'd0);
    do_req(1'b0, 16'h0010, 4'b1111, 32'd0, rd, er, lat);
    chk("post_rst_rd",  rd,       32'hDEADAAEF);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_err", 32'(er),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
